// File: rtl/otter_pkg.sv
// Shared types for the OTTER control unit.
// Holds the state and opcode encodings used by cu_fsm.
package otter_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } state_t;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_SYSTEM = 7'b1110011
  } opcode_t;

  localparam logic [2:0] F3_MRET  = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;
  localparam logic [2:0] F3_CSRRS = 3'b010;
  localparam logic [2:0] F3_CSRRC = 3'b011;

endpackage

// File: rtl/cu_fsm.sv
// OTTER multicycle control unit.
// Registered state, combinational strobes from state and IR.
module cu_fsm
  import otter_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       intr,
  input  logic [6:0] ir_opcode,
  input  logic [2:0] ir_func,
  output logic       PCWrite,
  output logic       regWrite,
  output logic       memWE2,
  output logic       memRDEN1,
  output logic       memRDEN2,
  output logic       reset,
  output logic       csr_WE,
  output logic       int_taken,
  output logic       mret_exec
);

  state_t state;
  state_t next_state;
  opcode_t opc;

  assign opc = opcode_t'(ir_opcode);

  // State register; reset wins over every transition
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_INIT;
    else     state <= next_state;
  end

  // Next-state and strobe decode
  always_comb begin
    next_state = ST_INIT;
    PCWrite    = 1'b0;
    regWrite   = 1'b0;
    memWE2     = 1'b0;
    memRDEN1   = 1'b0;
    memRDEN2   = 1'b0;
    reset      = 1'b0;
    csr_WE     = 1'b0;
    int_taken  = 1'b0;
    mret_exec  = 1'b0;
    unique case (state)
      ST_INIT: begin
        reset      = 1'b1;
        next_state = ST_FETCH;
      end
      ST_FETCH: begin
        memRDEN1   = 1'b1;
        next_state = ST_EXEC;
      end
      ST_EXEC: begin
        if (opc == OPC_LOAD) begin
          memRDEN2   = 1'b1;
          next_state = ST_WB;
        end else begin
          PCWrite    = 1'b1;
          next_state = intr ? ST_INTR : ST_FETCH;
          case (opc)
            OPC_STORE: memWE2 = 1'b1;
            OPC_OP, OPC_OP_IMM, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR:
              regWrite = 1'b1;
            OPC_SYSTEM: begin
              case (ir_func)
                F3_MRET: mret_exec = 1'b1;
                F3_CSRRW, F3_CSRRS, F3_CSRRC: begin
                  regWrite = 1'b1;
                  csr_WE   = 1'b1;
                end
                default: ;
              endcase
            end
            default: ;
          endcase
        end
      end
      ST_WB: begin
        regWrite   = 1'b1;
        PCWrite    = 1'b1;
        next_state = intr ? ST_INTR : ST_FETCH;
      end
      ST_INTR: begin
        int_taken  = 1'b1;
        PCWrite    = 1'b1;
        next_state = ST_FETCH;
      end
      default: next_state = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_cu_fsm.sv
// Self-checking bench for cu_fsm.
// Builds the expected per-cycle strobe trace of each instruction.
module tb_cu_fsm;

  logic       CLK;
  logic       RST;
  logic       intr;
  logic [6:0] ir_opcode;
  logic [2:0] ir_func;
  logic       PCWrite, regWrite, memWE2, memRDEN1, memRDEN2;
  logic       reset, csr_WE, int_taken, mret_exec;

  int nchk;
  int nerr;

  localparam logic [8:0] O_PC   = 9'h100;
  localparam logic [8:0] O_RW   = 9'h080;
  localparam logic [8:0] O_WE2  = 9'h040;
  localparam logic [8:0] O_RD1  = 9'h020;
  localparam logic [8:0] O_RD2  = 9'h010;
  localparam logic [8:0] O_RST  = 9'h008;
  localparam logic [8:0] O_CSR  = 9'h004;
  localparam logic [8:0] O_INT  = 9'h002;
  localparam logic [8:0] O_MRET = 9'h001;

  logic [8:0] outs;

  cu_fsm dut (
    .CLK       (CLK),
    .RST       (RST),
    .intr      (intr),
    .ir_opcode (ir_opcode),
    .ir_func   (ir_func),
    .PCWrite   (PCWrite),
    .regWrite  (regWrite),
    .memWE2    (memWE2),
    .memRDEN1  (memRDEN1),
    .memRDEN2  (memRDEN2),
    .reset     (reset),
    .csr_WE    (csr_WE),
    .int_taken (int_taken),
    .mret_exec (mret_exec)
  );

  assign outs = {PCWrite, regWrite, memWE2, memRDEN1, memRDEN2,
                 reset, csr_WE, int_taken, mret_exec};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [8:0] got,
                       input logic [8:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Strobes an instruction raises in its execute cycle.
  function automatic logic [8:0] exec_out(input logic [6:0] op,
                                          input logic [2:0] f3);
    case (op)
      7'b0000011: return O_RD2;
      7'b0100011: return O_PC | O_WE2;
      7'b1100011: return O_PC;
      7'b0110011, 7'b0010011, 7'b0110111,
      7'b0010111, 7'b1101111, 7'b1100111:
        return O_PC | O_RW;
      7'b1110011: begin
        if (f3 == 3'b000) return O_PC | O_MRET;
        if (f3 >= 3'b001 && f3 <= 3'b011)
          return O_PC | O_RW | O_CSR;
        return O_PC;
      end
      default: return O_PC;
    endcase
  endfunction

  // One instruction: fetch, execute, optional writeback,
  // optional interrupt entry. rst_at aborts at that cycle.
  task automatic do_instr(input string tag, input logic [6:0] op,
                          input logic [2:0] f3, input logic fintr,
                          input logic take, input int rst_at);
    logic [8:0] expv[4];
    logic       iv[4];
    int         n;
    bit         ld;
    ld = (op == 7'b0000011);
    n = 0;
    expv[n] = O_RD1;
    iv[n] = fintr;
    n++;
    expv[n] = exec_out(op, f3);
    iv[n] = ld ? 1'($urandom_range(0, 1)) : take;
    n++;
    if (ld) begin
      expv[n] = O_PC | O_RW;
      iv[n] = take;
      n++;
    end
    if (take) begin
      expv[n] = O_PC | O_INT;
      iv[n] = 1'($urandom_range(0, 1));
      n++;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      ir_opcode = op;
      ir_func = f3;
      intr = iv[i];
      RST = (i == rst_at);
      #1 check($sformatf("%s c%0d", tag, i), outs, expv[i]);
      if (i == rst_at) begin
        @(negedge CLK);
        RST = 1'b0;
        intr = 1'($urandom_range(0, 1));
        #1 check($sformatf("%s init", tag), outs, O_RST);
        return;
      end
    end
  endtask

  logic [6:0] ops[10];

  initial begin
    nchk = 0;
    nerr = 0;
    ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011,
            7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
            7'b1100111, 7'b1110011};
    RST = 1'b1;
    intr = 1'b1;
    ir_opcode = 7'd0;
    ir_func = 3'd0;
    @(negedge CLK);
    #1 check("reset held", outs, O_RST);
    RST = 1'b0;
    #1 check("reset init", outs, O_RST);

    do_instr("add", 7'b0110011, 3'b000, 1'b0, 1'b0, -1);
    do_instr("lw", 7'b0000011, 3'b010, 1'b0, 1'b0, -1);
    do_instr("sw_int", 7'b0100011, 3'b010, 1'b0, 1'b1, -1);
    do_instr("after_int", 7'b0110011, 3'b000, 1'b1, 1'b0, -1);
    do_instr("csrrw", 7'b1110011, 3'b001, 1'b0, 1'b0, -1);
    do_instr("mret_int", 7'b1110011, 3'b000, 1'b0, 1'b1, -1);
    do_instr("beq_fint", 7'b1100011, 3'b000, 1'b1, 1'b0, -1);
    do_instr("beq_next", 7'b1100011, 3'b001, 1'b0, 1'b0, -1);
    do_instr("lw_wb_rst", 7'b0000011, 3'b010, 1'b0, 1'b1, 2);
    do_instr("lw_int", 7'b0000011, 3'b010, 1'b1, 1'b1, -1);
    do_instr("intr_rst", 7'b0100011, 3'b000, 1'b0, 1'b1, 2);
    do_instr("sys_nop", 7'b1110011, 3'b101, 1'b0, 1'b0, -1);
    do_instr("bad_op", 7'b1111111, 3'b000, 1'b0, 1'b0, -1);

    for (int k = 0; k < 400; k++) begin
      logic [6:0] op;
      int ra;
      if ($urandom_range(0, 4) == 0) op = 7'($urandom);
      else op = ops[$urandom_range(0, 9)];
      ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      do_instr($sformatf("rnd%0d", k), op, 3'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/cu_fsm.md
CU_FSM -- requirements
Module: cu_fsm

Interface
REQ-001 Parameters: none.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 CLK  in  1  system clock; all state updates on the rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 intr  in  1  interrupt request, already masked by MIE; level-sensitive.
REQ-006 ir_opcode  in  7  instruction opcode field, bits [6:0].
REQ-007 ir_func  in  3  instruction func3 field, bits [14:12].
REQ-008 PCWrite  out  1  PC register load enable.
REQ-009 regWrite  out  1  register file write enable.
REQ-010 memWE2  out  1  data-port memory write enable.
REQ-011 memRDEN1  out  1  instruction-port memory read enable.
REQ-012 memRDEN2  out  1  data-port memory read enable.
REQ-013 reset  out  1  PC and register file reset strobe.
REQ-014 csr_WE  out  1  CSR file write enable.
REQ-015 int_taken  out  1  interrupt entry strobe to the CSR file and PC mux.
REQ-016 mret_exec  out  1  MRET strobe to the CSR file.

Function
REQ-017 States SHALL be INIT, FETCH, EXEC, WB and INTR.
REQ-018 State is registered. Outputs are combinational from the current state, ir_opcode and ir_func. Any output not listed for a state/opcode SHALL be 0.
REQ-019 INIT: reset=1; next state FETCH unconditionally.
REQ-020 FETCH: memRDEN1=1; next state EXEC unconditionally; intr is ignored.
REQ-021 EXEC, LOAD (0000011): memRDEN2=1, PCWrite=0; next state WB.
REQ-022 EXEC, STORE (0100011): memWE2=1, PCWrite=1.
REQ-023 EXEC, BRANCH (1100011): PCWrite=1; branch target selection is external.
REQ-024 EXEC, OP (0110011), OP-IMM (0010011), LUI (0110111), AUIPC (0010111), JAL (1101111), JALR (1100111): PCWrite=1, regWrite=1.
REQ-025 EXEC, SYSTEM (1110011), func3 000 (MRET): PCWrite=1, mret_exec=1.
REQ-026 EXEC, SYSTEM, func3 001/010/011 (CSRRW/CSRRS/CSRRC): PCWrite=1, regWrite=1, csr_WE=1.
REQ-027 EXEC, SYSTEM with any other func3, and any unlisted opcode: PCWrite=1 only, executed as a NOP.
REQ-028 EXEC exit for non-LOAD opcodes: intr=1 -> INTR; else FETCH.
REQ-029 WB: regWrite=1, PCWrite=1; next state INTR if intr=1, else FETCH.
REQ-030 INTR: int_taken=1, PCWrite=1; next state FETCH unconditionally. No nesting; intr is ignored in INTR.
REQ-031 Latency per instruction:
- 2 cycles for non-load instructions.
- 3 cycles for loads.
- +1 cycle when an interrupt is taken.
REQ-032 MRET with intr=1 in the same EXEC cycle: mret_exec=1 in EXEC, then INTR.

Reset
REQ-033 RST=1 at a rising edge SHALL force state INIT from any state, including mid-EXEC/WB/INTR. No pending interrupt is retained.
REQ-034 While in INIT after reset, outputs SHALL be reset=1 and all others 0.
REQ-035 RST SHALL take priority over all transitions and over intr.

Structure
REQ-036 The opcode enum and the state enum SHALL live in the shared package otter_pkg.
REQ-037 The block SHALL be a single module (state register plus combinational next-state/output logic); no sub-module.

Verification
REQ-038 RST=1 for 1 cycle, then ADD (opcode 0110011):
- INIT: reset=1.
- FETCH: memRDEN1=1.
- EXEC: PCWrite=1, regWrite=1.
- Next cycle: back in FETCH.
REQ-039 LW (0000011, func3 010):
- EXEC: memRDEN2=1, PCWrite=0.
- WB: regWrite=1, PCWrite=1.
- Then FETCH.
REQ-040 SW (0100011) with intr=1 in EXEC:
- EXEC: memWE2=1, PCWrite=1.
- INTR: int_taken=1, PCWrite=1.
- Then FETCH, even with intr still 1.
REQ-041 CSRRW (1110011, func3 001):
- EXEC: csr_WE=1, regWrite=1, PCWrite=1.
- MRET (func3 000) with intr=1: mret_exec=1, then INTR.
REQ-042 intr=1 asserted only during FETCH and deasserted in EXEC of a BEQ: no INTR visit; EXEC -> FETCH.
REQ-043 RST=1 during WB of a load: next cycle INIT with reset=1, regWrite=0; INTR never entered.
